// File: rtl/config_bitstream_if.sv
// Serial configuration link between the bitstream generator (master) and the
// loader (slave), plus the parallel image and status the loader presents.
interface config_bitstream_if #(
  parameter int NUM_BITS    = 832,
  parameter int COUNT_WIDTH = 32
);
  // Valid-only stream: the loader has no ready and always accepts. A bit is
  // taken at every rising edge where bitstream_valid is high while loading.
  // done is a level and may coincide with the final valid bit.
  logic                   bitstream;
  logic                   bitstream_valid;
  logic                   done;
  logic [0:NUM_BITS-1]    config_out;
  logic                   config_valid;
  logic                   config_error;
  logic                   loading;
  logic [COUNT_WIDTH-1:0] bit_count;
  logic [1:0]             state_dbg;

  modport master (
    output bitstream, bitstream_valid, done,
    input  config_out, config_valid, config_error, loading, bit_count, state_dbg
  );

  modport slave (
    input  bitstream, bitstream_valid, done,
    output config_out, config_valid, config_error, loading, bit_count, state_dbg
  );
endinterface

// File: rtl/config_bitstream_loader.sv
// Deserializes the configuration bitstream into a shadow register and commits
// it to the fabric image only when exactly NUM_BITS bits arrived before done.
module config_bitstream_loader #(
  parameter int NUM_BITS    = 832,
  parameter int COUNT_WIDTH = 32
) (
  input logic               clock,
  input logic               sync_reset,
  config_bitstream_if.slave bus
);
  localparam logic [1:0] LOAD      = 2'd0;
  localparam logic [1:0] COMMITTED = 2'd1;
  localparam logic [1:0] FAILED    = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT    = COUNT_WIDTH'(NUM_BITS);
  localparam logic [COUNT_WIDTH-1:0] OVERRUN_COUNT = COUNT_WIDTH'(NUM_BITS + 1);

  logic [1:0]             state;
  logic [0:NUM_BITS-1]    shadow;
  logic [0:NUM_BITS-1]    shadow_next;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [0:NUM_BITS-1]    image;
  logic                   image_valid;
  logic                   load_error;

  // Next shadow/count include a bit arriving in the same cycle as done, so the
  // commit decision sees the effective count.
  always_comb begin
    shadow_next = shadow;
    count_next  = count;
    if (bus.bitstream_valid) begin
      if (count < FULL_COUNT) begin
        shadow_next = {shadow[1:NUM_BITS-1], bus.bitstream};
        count_next  = count + COUNT_WIDTH'(1);
      end else begin
        count_next  = OVERRUN_COUNT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      state       <= LOAD;
      shadow      <= '0;
      count       <= '0;
      image       <= '0;
      image_valid <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          shadow <= shadow_next;
          count  <= count_next;
          if (bus.done) begin
            if (count_next == FULL_COUNT) begin
              image       <= shadow_next;
              image_valid <= 1'b1;
              state       <= COMMITTED;
            end else begin
              load_error  <= 1'b1;
              state       <= FAILED;
            end
          end
        end
        COMMITTED, FAILED: state <= state;
        default:           state <= FAILED;
      endcase
    end
  end

  assign bus.config_out   = image;
  assign bus.config_valid = image_valid;
  assign bus.config_error = load_error;
  assign bus.loading      = (state == LOAD);
  assign bus.bit_count    = count;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_config_bitstream_loader.sv
// Directed bench: an 8-bit loader for the protocol corner cases and a full
// 832-bit loader fed by a generator-style stream.
module tb_config_bitstream_loader;
  logic clock = 1'b0;
  logic sync_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  config_bitstream_if #(.NUM_BITS(8),   .COUNT_WIDTH(32)) bus8 ();
  config_bitstream_if #(.NUM_BITS(832), .COUNT_WIDTH(32)) bus_full ();

  config_bitstream_loader #(.NUM_BITS(8), .COUNT_WIDTH(32)) dut8 (
    .clock(clock), .sync_reset(sync_reset), .bus(bus8.slave)
  );
  config_bitstream_loader #(.NUM_BITS(832), .COUNT_WIDTH(32)) dut_full (
    .clock(clock), .sync_reset(sync_reset), .bus(bus_full.slave)
  );

  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock on the 8-bit loader: inputs set at a falling edge, outputs
  // settled at the next falling edge.
  task automatic step8(input logic v, input logic b, input logic d, input logic r);
    bus8.bitstream_valid = v;
    bus8.bitstream       = b;
    bus8.done            = d;
    sync_reset           = r;
    @(negedge clock);
  endtask

  task automatic send8(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) step8(1'b1, bits[7-i], 1'b0, 1'b0);
    step8(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset8();
    step8(1'b0, 1'b0, 1'b0, 1'b1);
    step8(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check8(input string tag, input logic [7:0] out, input logic valid,
                        input logic err, input logic load, input int cnt);
    check({tag, ".config_out"},   64'(bus8.config_out),   64'(out));
    check({tag, ".config_valid"}, 64'(bus8.config_valid), 64'(valid));
    check({tag, ".config_error"}, 64'(bus8.config_error), 64'(err));
    check({tag, ".loading"},      64'(bus8.loading),      64'(load));
    check({tag, ".bit_count"},    64'(bus8.bit_count),    64'(cnt));
  endtask

  function automatic logic pattern_bit(input int i);
    return logic'((i % 5 == 0) ^ ((i / 8) % 2 == 1) ^ (i % 3 == 2));
  endfunction

  initial begin
    logic [7:0] gap_len [8];
    logic [0:831] exp_img;
    logic [0:831] got_img;

    gap_len = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd3, 8'd1, 8'd2};
    bus_full.bitstream       = 1'b0;
    bus_full.bitstream_valid = 1'b0;
    bus_full.done            = 1'b0;
    @(negedge clock);
    reset8();
    check8("reset", 8'h00, 1'b0, 1'b0, 1'b1, 0);
    check("reset.full_loading", 64'(bus_full.loading), 64'd1);

    // Exact load commits in the cycle after done.
    send8(8'b10110010, 8);
    check8("t1_pre_done", 8'h00, 1'b0, 1'b0, 1'b1, 8);
    step8(1'b0, 1'b0, 1'b1, 1'b0);
    check8("t1", 8'b10110010, 1'b1, 1'b0, 1'b0, 8);
    step8(1'b1, 1'b1, 1'b1, 1'b0);
    check8("t1_hold", 8'b10110010, 1'b1, 1'b0, 1'b0, 8);
    reset8();
    check8("t1_reset_clears", 8'h00, 1'b0, 1'b0, 1'b1, 0);

    // Short load fails; later bits are ignored.
    send8(8'b1011001x, 7);
    step8(1'b0, 1'b0, 1'b1, 1'b0);
    check8("t2", 8'h00, 1'b0, 1'b1, 1'b0, 7);
    step8(1'b1, 1'b1, 1'b1, 1'b0);
    step8(1'b1, 1'b0, 1'b1, 1'b0);
    check8("t2_ignore", 8'h00, 1'b0, 1'b1, 1'b0, 7);
    reset8();

    // Overrun saturates at NUM_BITS+1.
    send8(8'b11110000, 8);
    send8(8'b11000000, 2);
    check("t3_pre_done.bit_count", 64'(bus8.bit_count), 64'd9);
    step8(1'b0, 1'b0, 1'b1, 1'b0);
    check8("t3", 8'h00, 1'b0, 1'b1, 1'b0, 9);
    reset8();

    // Final bit arrives with done.
    send8(8'b10000000, 7);
    step8(1'b1, 1'b1, 1'b1, 1'b0);
    check8("t4", 8'b10000001, 1'b1, 1'b0, 1'b0, 8);
    reset8();

    // Reset mid-load restarts reception; gapped stream then commits.
    send8(8'b11110000, 4);
    step8(1'b0, 1'b0, 1'b0, 1'b1);
    check8("t5_reset", 8'h00, 1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < int'(gap_len[i]); g++) step8(1'b0, 1'b1, 1'b0, 1'b0);
      step8(1'b1, logic'(i % 2), 1'b0, 1'b0);
    end
    step8(1'b0, 1'b0, 1'b1, 1'b0);
    check8("t5", 8'b01010101, 1'b1, 1'b0, 1'b0, 8);
    step8(1'b0, 1'b0, 1'b1, 1'b0);

    // Full-size load: generator enable registered into valid, gated by done.
    for (int i = 0; i < 832; i++) exp_img[i] = pattern_bit(i);
    for (int k = 0; k < 13; k++) exp_q.push_back(exp_img[k*64 +: 64]);
    for (int i = 0; i < 832; i++) begin
      bus_full.bitstream_valid = 1'b1;
      bus_full.bitstream       = pattern_bit(i);
      @(negedge clock);
    end
    bus_full.bitstream_valid = 1'b0;
    check("t6_pre_done.config_valid", 64'(bus_full.config_valid), 64'd0);
    check("t6_pre_done.bit_count",    64'(bus_full.bit_count),    64'd832);
    bus_full.done = 1'b1;
    @(negedge clock);
    check("t6.config_valid", 64'(bus_full.config_valid), 64'd1);
    check("t6.config_error", 64'(bus_full.config_error), 64'd0);
    check("t6.loading",      64'(bus_full.loading),      64'd0);
    check("t6.bit_count",    64'(bus_full.bit_count),    64'd832);
    got_img = bus_full.config_out;
    for (int k = 0; k < 13; k++) begin
      check($sformatf("t6.chunk%0d", k), got_img[k*64 +: 64], exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/config_bitstream_loader.md
Name: config_bitstream_loader

Overview:
- Receive end of the serial configuration bitstream protocol.
- Deserializes the 1-bit-per-cycle stream from the bitstream generator into a NUM_BITS-wide shadow register and counts received bits.
- When the generator signals done, commits the shadow register to the active configuration output if exactly NUM_BITS bits arrived; otherwise flags an error.
- Sits between the configuration generator and the CGRA fabric configuration cells; its output is the parallel image the fabric consumes.

Parameters:
NUM_BITS, 832, total configuration bits expected per load.
COUNT_WIDTH, 32, width of the received-bit counter and bit_count output.

Ports:
clock  input  1  single clock, rising-edge.
sync_reset  input  1  synchronous, active-high reset.
bitstream  input  1  serial configuration bit.
bitstream_valid  input  1  bitstream carries a real bit this cycle.
done  input  1  generator finished; level, held high until the generator is reset.
config_out  output  NUM_BITS  active configuration image, indexed [0:NUM_BITS-1]; index 0 = first bit received.
config_valid  output  1  config_out holds a successfully committed load.
config_error  output  1  last load ended with bit count != NUM_BITS.
loading  output  1  block is in LOAD state.
bit_count  output  COUNT_WIDTH  bits accepted in current load (saturating, see below).

Behaviour:
- All state is registered on the rising edge of clock. No combinational input-to-output paths except decoding of loading from the state register.
- Reset (sync_reset=1 at an edge), dominant over all other inputs:
  - shadow register = 0, bit_count = 0, config_out = 0.
  - config_valid = 0, config_error = 0.
  - state = LOAD, so loading = 1.
- States: LOAD, COMMITTED, FAILED. Exit from COMMITTED or FAILED only via sync_reset.
- LOAD, bitstream_valid=1:
  - If bit_count < NUM_BITS: shadow <= {shadow[1:NUM_BITS-1], bitstream}, i.e. shift toward index 0 with the new bit at index NUM_BITS-1. bit_count increments.
  - If bit_count >= NUM_BITS: shadow is not shifted (overrun). bit_count becomes NUM_BITS+1 and saturates there.
- LOAD, bitstream_valid=0: shadow and bit_count hold. Gaps of any length are legal.
- LOAD, done=1 at an edge. Evaluate effective count = bit_count plus 1 if bitstream_valid is also high this cycle (that bit is accepted first, same rules as above).
  - Effective count == NUM_BITS: config_out <= shadow including any same-cycle bit; config_valid <= 1; state <= COMMITTED.
  - Otherwise: config_error <= 1; config_out unchanged; config_valid stays 0; state <= FAILED.
- Latency: done sampled at edge N → config_out, config_valid, config_error and loading all updated at edge N. Visible in the cycle after edge N.
- COMMITTED / FAILED: bitstream, bitstream_valid and done are ignored. All outputs hold.
- Bit values are stored verbatim. Don't-care bits from the generator land as whatever value the stream carried; benches compare only specified bits.
- Reset during LOAD discards partial data, zeroes the counter, and restarts reception.
- Reset in COMMITTED clears config_out; the fabric must be reloaded.

Test Plan:
1. NUM_BITS=8; send 1,0,1,1,0,0,1,0 on consecutive valid cycles, then done=1 → one cycle later config_out[0:7]=10110010, config_valid=1, config_error=0, bit_count=8, loading=0.
2. NUM_BITS=8; send 7 bits then done → config_error=1, config_valid=0, config_out=0, bit_count=7. Further valid bits are ignored; bit_count stays 7.
3. NUM_BITS=8; send 10 bits (first eight 11110000, then 1,1), then done → config_error=1, bit_count=9 (saturated), config_out=0.
4. NUM_BITS=8; send 7 bits, then assert the 8th bit (value 1) together with done in the same cycle → config_valid=1, config_out[7]=1, bit_count=8.
5. NUM_BITS=8; send 4 bits, assert sync_reset 1 cycle, then send 01010101 with gaps of 0–3 idle cycles between bits, then done → config_out=01010101, config_valid=1.
6. NUM_BITS=832; drive from the configuration generator (enable held high, bitstream_valid = enable registered one cycle, gated by !done) with a known pattern → config_valid=1 one cycle after done, all 832 bits match the pattern, bit_count=832.
